tdm_demux: RTL

- Time-division demultiplexer: the receive-side counterpart of the team's N:1 selection muxes.
- Accepts one serial lane of time-multiplexed samples, with a start-of-frame marker on slot 0.
- Steers each sample to its channel slot, then presents a completed frame of NUM_CH samples as one parallel word with a valid/ready handshake.
- Sits between the serial TDM link and per-channel consumers.
- Double-buffered, so the next frame can be collected while the previous one waits for the consumer.

---
 rtl/tdm_pkg.sv | 15 +
 rtl/tdm_out_buf.sv | 54 +++++
 rtl/tdm_demux.sv | 120 ++++++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM demultiplexer family.
//   - state_e  : collection FSM states
//   - DefNumCh : default channels per frame
//   - DefDataW : default bits per sample
package tdm_pkg;

  localparam int unsigned DefNumCh = 4;
  localparam int unsigned DefDataW = 8;

  typedef enum logic [0:0] {
    StIdle,
    StCollect
  } state_e;

endpackage

// File: rtl/tdm_out_buf.sv
// Single-entry valid/ready holding register.
// A load is accepted when the entry is empty or is being drained the same
// cycle; otherwise the offered word is dropped and overflow pulses.
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   load, load_data : offer a new word this cycle
//   ready           : consumer takes the held word when valid && ready
//   valid, data     : held word
//   overflow        : one-cycle pulse, offered word was dropped
module tdm_out_buf #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [Width-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [Width-1:0] data,
  output logic             overflow
);

  logic             valid_q;
  logic [Width-1:0] data_q;
  logic             overflow_q;
  logic             accept;
  logic             drop;

  always_comb begin
    accept = load && (!valid_q || ready);
    drop   = load && valid_q && !ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      data_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= drop;
      if (accept) begin
        valid_q <= 1'b1;
        data_q  <= load_data;
      end else if (ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign valid    = valid_q;
  assign data     = data_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: collects NUM_CH serial samples (slot 0 marked
// by in_sof) into a frame and hands it to a double-buffered parallel output.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   in_valid, in_sof, in_data  : serial sample lane (no backpressure)
//   out_valid, out_ready       : frame handshake
//   out_data                   : channel k at [k*DATA_W +: DATA_W]
//   ch_strobe                  : one-hot pulse, slot k was written
//   frame_err                  : pulse, sof arrived mid-frame (resync)
//   overflow                   : pulse, completed frame dropped
module tdm_demux
  import tdm_pkg::*;
#(
  parameter  int unsigned NUM_CH = DefNumCh,
  parameter  int unsigned DATA_W = DefDataW,
  localparam int unsigned CNT_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic                     in_sof,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        ch_strobe,
  output logic                     frame_err,
  output logic                     overflow
);

  state_e                         state_q;
  logic [CNT_W-1:0]               slot_q;
  logic [NUM_CH-1:0][DATA_W-1:0]  collect_q;
  logic [NUM_CH-1:0]              ch_strobe_q;
  logic                           frame_err_q;

  logic                           sof_hit;
  logic                           data_hit;
  logic                           last_slot;
  logic                           frame_done;
  logic                           resync;
  logic                           wr_en;
  logic [CNT_W-1:0]               wr_slot;
  logic [NUM_CH-1:0]              ch_strobe_d;
  logic [NUM_CH-1:0][DATA_W-1:0]  frame_word;

  always_comb begin
    sof_hit    = in_valid && in_sof;
    // Non-sof samples only count once a frame has been opened.
    data_hit   = in_valid && !in_sof && (state_q == StCollect);
    last_slot  = (slot_q == CNT_W'(NUM_CH - 1));
    frame_done = data_hit && last_slot;
    resync     = sof_hit && (state_q == StCollect);
    wr_en      = sof_hit || data_hit;
    wr_slot    = sof_hit ? '0 : slot_q;

    ch_strobe_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      ch_strobe_d[k] = wr_en && (wr_slot == CNT_W'(k));
    end

    // The completing sample bypasses the collect buffer so the whole frame
    // reaches the output register on the same edge.
    frame_word = collect_q;
    for (int k = 0; k < NUM_CH; k++) begin
      if (slot_q == CNT_W'(k)) begin
        frame_word[k] = in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      slot_q      <= '0;
      collect_q   <= '0;
      ch_strobe_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      ch_strobe_q <= ch_strobe_d;
      frame_err_q <= resync;

      for (int k = 0; k < NUM_CH; k++) begin
        if (wr_en && (wr_slot == CNT_W'(k))) begin
          collect_q[k] <= in_data;
        end
      end

      if (sof_hit) begin
        // Start or restart a frame; a stale partial frame is simply overwritten.
        state_q <= StCollect;
        slot_q  <= CNT_W'(1);
      end else if (data_hit) begin
        if (last_slot) begin
          state_q <= StIdle;
          slot_q  <= '0;
        end else begin
          slot_q <= slot_q + CNT_W'(1);
        end
      end
    end
  end

  tdm_out_buf #(
    .Width(NUM_CH * DATA_W)
  ) u_out_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (frame_done),
    .load_data(frame_word),
    .ready    (out_ready),
    .valid    (out_valid),
    .data     (out_data),
    .overflow (overflow)
  );

  assign ch_strobe = ch_strobe_q;
  assign frame_err = frame_err_q;

endmodule
